// File: rtl/divisor_sequencial_if.sv
// Handshake and operand/result bundle between the controlling FSM (master)
// and the sequential divider (slave).
interface divisor_sequencial_if;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/divisor_sequencial.sv
// Iterative restoring divider: 8-bit dividend / 4-bit divisor, one quotient
// bit per clock. Divide-by-zero short-circuits straight to DONE with an
// all-ones quotient and the error flag set.
module divisor_sequencial (
    input  logic                 clk,
    input  logic                 rst_n,
    divisor_sequencial_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_rem;        // partial remainder; always < divisor, so 4 bits hold it
    logic [7:0] r_q;          // dividend shifting out MSB-first, quotient shifting in
    logic [3:0] r_d;          // latched divisor
    logic [2:0] r_cnt;        // iteration index 0..7
    logic [7:0] r_quotient;
    logic [3:0] r_remainder;
    logic       r_busy;
    logic       r_done;
    logic       r_dbz;

    logic [4:0] w_trial;      // 5-bit trial value so the compare cannot overflow
    logic       w_ge;
    logic [3:0] w_rem_next;
    logic [7:0] w_q_next;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        w_trial    = {r_rem, r_q[7]};
        w_ge       = (w_trial >= {1'b0, r_d});
        w_rem_next = w_trial[3:0];
        if (w_ge) begin
            // The true difference is < D <= 15, so 4-bit wraparound is exact.
            w_rem_next = w_trial[3:0] - r_d;
        end else begin
            w_rem_next = w_trial[3:0];
        end
        w_q_next = {r_q[6:0], w_ge};
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rem       <= 4'd0;
            r_q         <= 8'd0;
            r_d         <= 4'd0;
            r_cnt       <= 3'd0;
            r_quotient  <= 8'd0;
            r_remainder <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != 4'd0) begin
                            r_q     <= bus.dividend;
                            r_d     <= bus.divisor;
                            r_rem   <= 4'd0;
                            r_cnt   <= 3'd0;
                            r_busy  <= 1'b1;
                            r_state <= ST_CALC;
                        end else begin
                            r_quotient  <= 8'hFF;
                            r_remainder <= 4'd0;
                            r_dbz       <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                        r_dbz       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_state <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: directed cases, product sweep,
// back-to-back/ignored-start handling, mid-operation reset and random operands
// compared against plain-arithmetic expectations.
module tb_divisor_sequencial;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] exp_q_last;
    logic [3:0] exp_r_last;
    logic       exp_z_last;

    divisor_sequencial_if bus ();

    divisor_sequencial dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer division, all-ones quotient on zero divisor.
    task automatic model(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r, output logic z);
        if (b == 4'd0) begin
            q = 8'hFF; r = 4'd0; z = 1'b1;
        end else begin
            q = 8'(int'(a) / int'(b));
            r = 4'(int'(a) % int'(b));
            z = 1'b0;
        end
    endtask

    task automatic do_div(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        int         cyc;
        int         bcnt;
        model(a, b, eq, er, ez);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
        cyc  = 1;
        bcnt = 0;
        if (b != 4'd0) begin
            chk("hold_quot", 16'(bus.quotient), 16'(exp_q_last));
            chk("hold_dbz", 16'(bus.div_by_zero), 16'(exp_z_last));
        end
        while (!bus.done && cyc < 20) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", 16'(bus.done), 16'd1);
        chk("latency", 16'(cyc), (b == 4'd0) ? 16'd1 : 16'd9);
        chk("busy_cycles", 16'(bcnt), (b == 4'd0) ? 16'd0 : 16'd8);
        chk("busy_with_done", 16'(bus.busy), 16'd0);
        chk("quot", 16'(bus.quotient), 16'(eq));
        chk("rem", 16'(bus.remainder), 16'(er));
        chk("dbz", 16'(bus.div_by_zero), 16'(ez));
        @(negedge clk);
        chk("done_one_cycle", 16'(bus.done), 16'd0);
        chk("quot_held", 16'(bus.quotient), 16'(eq));
        exp_q_last = eq;
        exp_r_last = er;
        exp_z_last = ez;
    endtask

    // Hard stop guard in case something upstream never returns.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ba [3];
        logic [3:0] bb [3];
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        int         idx;
        int         t;
        int         last_t;

        ba[0] = 8'd143; ba[1] = 8'd200; ba[2] = 8'd7;
        bb[0] = 4'd11;  bb[1] = 4'd15;  bb[2] = 4'd9;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor  = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_quot", 16'(bus.quotient), 16'd0);
        chk("rst_rem", 16'(bus.remainder), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_done", 16'(bus.done), 16'd0);
        chk("rst_dbz", 16'(bus.div_by_zero), 16'd0);
        rst_n = 1'b1;
        exp_q_last = 8'd0; exp_r_last = 4'd0; exp_z_last = 1'b0;

        // Directed cases, including zero divisor and recovery afterwards.
        do_div(8'd143, 4'd11);
        do_div(8'd200, 4'd15);
        do_div(8'd255, 4'd1);
        do_div(8'd7,   4'd9);
        do_div(8'd100, 4'd0);
        do_div(8'd143, 4'd11);
        do_div(8'd0,   4'd0);
        do_div(8'd0,   4'd15);

        // Product sweep: A*B divides back to A with zero remainder.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 1; bi < 16; bi++) begin
                do_div(8'(ai * bi), 4'(bi));
                chk("sweep_quot", 16'(bus.quotient), 16'(ai));
                chk("sweep_rem", 16'(bus.remainder), 16'd0);
            end
        end

        // Back-to-back with start held high outside CALC and random re-pulses inside it.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = ba[0];
        bus.divisor  = bb[0];
        idx    = 0;
        t      = 0;
        last_t = 0;
        while (idx < 3 && t < 100) begin
            @(negedge clk);
            t++;
            if (bus.done) begin
                model(ba[idx], bb[idx], eq, er, ez);
                chk("b2b_quot", 16'(bus.quotient), 16'(eq));
                chk("b2b_rem", 16'(bus.remainder), 16'(er));
                chk("b2b_busy_with_done", 16'(bus.busy), 16'd0);
                if (idx > 0) chk("b2b_gap", 16'(t - last_t), 16'd10);
                last_t = t;
                idx++;
                if (idx < 3) begin
                    bus.dividend = ba[idx];
                    bus.divisor  = bb[idx];
                    bus.start    = 1'b1;
                end else begin
                    bus.start = 1'b0;
                end
            end else if (bus.busy) begin
                bus.start    = 1'($urandom_range(0, 1));
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
            end else begin
                bus.start = (idx < 3);
            end
        end
        chk("b2b_count", 16'(idx), 16'd3);
        bus.start  = 1'b0;
        exp_q_last = 8'd0; exp_r_last = 4'd7; exp_z_last = 1'b0;

        // Mid-operation reset after four iterations.
        do_div(8'd200, 4'd15);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd143;
        bus.divisor  = 4'd11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 16'(bus.busy), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_quot", 16'(bus.quotient), 16'd0);
        chk("mid_rst_rem", 16'(bus.remainder), 16'd0);
        chk("mid_rst_busy", 16'(bus.busy), 16'd0);
        chk("mid_rst_done", 16'(bus.done), 16'd0);
        chk("mid_rst_dbz", 16'(bus.div_by_zero), 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_no_done", 16'(bus.done), 16'd0);
        end
        exp_q_last = 8'd0; exp_r_last = 4'd0; exp_z_last = 1'b0;
        do_div(8'd143, 4'd11);

        // Random operands, zero divisor included naturally.
        repeat (60) begin
            do_div(8'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
